// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step and the buffered fetch entry layout.
package fetch_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_W = 32;
  localparam int PC_INC = 4;
  typedef struct packed {
    logic [INSTR_W-1:0]      instr;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with single-cycle flush; flush wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type T = fetch_entry_t,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop = pop_i && !empty_o && !flush_i;
  always_comb begin
    wr_d = flush_i ? '0 : wr_q + AW'(do_push);
    rd_d = flush_i ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: owns the fetch PC, issues credited req/gnt reads and buffers
// in-order responses for decode; redirect flushes and discards in-flight reads.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               redirect_valid_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               instr_mem_req_o,
  output logic [XLEN-1:0]    instr_mem_addr_o,
  input  logic               instr_mem_gnt_i,
  input  logic               mem_rd_valid_i,
  input  logic [INSTR_W-1:0] mem_rd_data_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    instr_pc_o,
  input  logic               instr_ready_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } entry_t;
  logic [XLEN-1:0] fpc_q, fpc_d, rpc_q, rpc_d, redir_pc;
  logic [CW-1:0] o_q, o_d, d_q, d_d, cnt;
  logic started_q, gnt_fire, rsp, push, pop, empty, full;
  entry_t head;
  assign redir_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
  // Outstanding plus buffered never exceeds DEPTH, so every response has a slot.
  assign instr_mem_req_o = started_q && !redirect_valid_i &&
                           (({1'b0, o_q} + {1'b0, cnt}) < (CW+1)'(DEPTH));
  assign instr_mem_addr_o = fpc_q;
  assign gnt_fire = instr_mem_req_o && instr_mem_gnt_i;
  assign rsp = mem_rd_valid_i && o_q != '0;
  assign push = rsp && d_q == '0 && !redirect_valid_i;
  assign pop = instr_valid_o && instr_ready_i;
  always_comb begin
    fpc_d = redirect_valid_i ? redir_pc : gnt_fire ? fpc_q + XLEN'(PC_INC) : fpc_q;
    rpc_d = redirect_valid_i ? redir_pc : push ? rpc_q + XLEN'(PC_INC) : rpc_q;
    o_d = o_q + CW'(gnt_fire) - CW'(rsp);
    d_d = redirect_valid_i ? o_q - CW'(rsp) : d_q - CW'(rsp && d_q != '0);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc_q <= RESET_PC;
      rpc_q <= RESET_PC;
      o_q <= '0;
      d_q <= '0;
      started_q <= 1'b0;
    end else begin
      fpc_q <= fpc_d;
      rpc_q <= rpc_d;
      o_q <= o_d;
      d_q <= d_d;
      started_q <= 1'b1;
    end
  end
  fetch_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (redirect_valid_i),
    .push_i  (push),
    .data_i  ('{instr: mem_rd_data_i, pc: rpc_q}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (cnt),
    .empty_o (empty),
    .full_o  (full)
  );
  assign instr_valid_o = !empty;
  assign instr_o = instr_valid_o ? head.instr : '0;
  assign instr_pc_o = instr_valid_o ? head.pc : '0;
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(mem_rd_valid_i && o_q == '0))
        else $warning("fetch_prefetch: response with no outstanding request ignored");
      assert (!(push && full)) else $error("fetch_prefetch: buffer overflow");
    end
  end
endmodule
